// File: rtl/sdrc_arb_pkg.sv
// Shared types and helpers for the SDRAM controller request-port arbiter.
package sdrc_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_XFR  = 2'd2
    } arb_state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int arb_id_w(input int n_ports);
        return (n_ports < 2) ? 1 : $clog2(n_ports);
    endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin select: the first requester at or after ptr, wrapping to 0.
module sdrc_rr_pick
    import sdrc_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ID_W    = arb_id_w(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [ID_W-1:0] cand;

    // Walk the ports starting at ptr and keep the first one that is requesting.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_PORTS);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sdrc_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller application request port.
// Ownership is held from grant until the controller reports the last data beat,
// so owner_id can steer the read/write data paths for the whole burst.
module sdrc_port_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 26,
    parameter int LEN_W   = 9,
    parameter int ACK_TMO = 255,
    localparam int ID_W   = arb_id_w(N_PORTS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_PORTS-1:0]        port_req,
    input  logic [N_PORTS*ADDR_W-1:0] port_addr,
    input  logic [N_PORTS*LEN_W-1:0]  port_len,
    input  logic [N_PORTS-1:0]        port_wr_n,
    output logic [N_PORTS-1:0]        port_ack,
    output logic                      owner_vld,
    output logic [ID_W-1:0]           owner_id,
    output logic                      app_req,
    output logic [ADDR_W-1:0]         app_req_addr,
    output logic [LEN_W-1:0]          app_req_len,
    output logic                      app_req_wr_n,
    input  logic                      app_req_ack,
    input  logic                      app_xfr_done,
    output logic                      ack_tmo_err
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);

    // Left as a plain internal signal so coverage interfaces can bind to it.
    arb_state_t      arb_state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic [ID_W-1:0] next_ptr;
    logic [TMO_W-1:0] tmo_cnt;

    sdrc_rr_pick #(
        .N_PORTS (N_PORTS),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (port_req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign next_ptr = (owner_id == ID_W'(N_PORTS - 1)) ? '0 : owner_id + 1'b1;

    // Arbitration FSM: grant in IDLE, hold the request until accepted, then wait for the burst to finish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_state    <= ARB_IDLE;
            rr_ptr       <= '0;
            owner_id     <= '0;
            owner_vld    <= 1'b0;
            app_req      <= 1'b0;
            app_req_addr <= '0;
            app_req_len  <= '0;
            app_req_wr_n <= 1'b0;
            port_ack     <= '0;
            tmo_cnt      <= '0;
            ack_tmo_err  <= 1'b0;
        end else begin
            port_ack    <= '0;
            ack_tmo_err <= 1'b0;
            case (arb_state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        owner_id     <= pick_idx;
                        owner_vld    <= 1'b1;
                        app_req      <= 1'b1;
                        app_req_addr <= port_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        app_req_len  <= port_len[int'(pick_idx)*LEN_W +: LEN_W];
                        app_req_wr_n <= port_wr_n[pick_idx];
                        tmo_cnt      <= TMO_W'(1);
                        ack_tmo_err  <= (ACK_TMO == 1);
                        arb_state    <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (app_req_ack) begin
                        app_req            <= 1'b0;
                        port_ack[owner_id] <= 1'b1;
                        rr_ptr             <= next_ptr;
                        if (app_xfr_done) begin
                            owner_vld <= 1'b0;
                            arb_state <= ARB_IDLE;
                        end else begin
                            arb_state <= ARB_XFR;
                        end
                    end else if (tmo_cnt != TMO_W'(ACK_TMO)) begin
                        tmo_cnt     <= tmo_cnt + 1'b1;
                        ack_tmo_err <= (tmo_cnt == TMO_W'(ACK_TMO - 1));
                    end
                end
                ARB_XFR: begin
                    if (app_xfr_done) begin
                        owner_vld <= 1'b0;
                        arb_state <= ARB_IDLE;
                    end
                end
                default: begin
                    arb_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_port_arbiter.sv
// Self-checking bench for sdrc_port_arbiter: transaction-level model plus directed scenarios.
module tb_sdrc_port_arbiter;

    localparam int N       = 4;
    localparam int AW      = 26;
    localparam int LW      = 9;
    localparam int ACK_TMO = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [N-1:0]  port_req = '0;
    logic [N*AW-1:0] port_addr = '0;
    logic [N*LW-1:0] port_len = '0;
    logic [N-1:0]  port_wr_n = '0;
    logic [N-1:0]  port_ack;
    logic          owner_vld;
    logic [1:0]    owner_id;
    logic          app_req;
    logic [AW-1:0] app_req_addr;
    logic [LW-1:0] app_req_len;
    logic          app_req_wr_n;
    logic          app_req_ack = 1'b0;
    logic          app_xfr_done = 1'b0;
    logic          ack_tmo_err;

    int n_pass = 0;
    int n_total = 0;

    sdrc_port_arbiter #(
        .N_PORTS (N),
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .ACK_TMO (ACK_TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .port_req     (port_req),
        .port_addr    (port_addr),
        .port_len     (port_len),
        .port_wr_n    (port_wr_n),
        .port_ack     (port_ack),
        .owner_vld    (owner_vld),
        .owner_id     (owner_id),
        .app_req      (app_req),
        .app_req_addr (app_req_addr),
        .app_req_len  (app_req_len),
        .app_req_wr_n (app_req_wr_n),
        .app_req_ack  (app_req_ack),
        .app_xfr_done (app_xfr_done),
        .ack_tmo_err  (ack_tmo_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic applyStimulus(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                                 input logic w, input logic r);
        port_addr[p*AW +: AW] = a;
        port_len[p*LW +: LW]  = l;
        port_wr_n[p]          = w;
        port_req[p]           = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the port, whether the controller accepted, how long we waited.
    int           m_owner = -1;
    bit           m_acked = 1'b0;
    int           m_req_cycles = 0;
    int           m_ptr = 0;
    logic [N-1:0] exp_port_ack = '0;
    logic         exp_tmo = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [LW-1:0] exp_len = '0;
    logic          exp_wr_n = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model_upd
        int p;
        if (!reset_n) begin
            m_owner      = -1;
            m_acked      = 1'b0;
            m_req_cycles = 0;
            m_ptr        = 0;
            exp_port_ack = '0;
            exp_tmo      = 1'b0;
        end else begin
            exp_port_ack = '0;
            exp_tmo      = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr + k) % N;
                    if (m_owner < 0 && port_req[p]) begin
                        m_owner      = p;
                        m_acked      = 1'b0;
                        m_req_cycles = 1;
                        exp_addr     = port_addr[p*AW +: AW];
                        exp_len      = port_len[p*LW +: LW];
                        exp_wr_n     = port_wr_n[p];
                        exp_tmo      = (ACK_TMO == 1);
                    end
                end
            end else if (!m_acked) begin
                if (app_req_ack) begin
                    exp_port_ack[m_owner] = 1'b1;
                    m_ptr = (m_owner + 1) % N;
                    if (app_xfr_done) m_owner = -1;
                    else m_acked = 1'b1;
                end else begin
                    m_req_cycles++;
                    if (m_req_cycles == ACK_TMO) exp_tmo = 1'b1;
                end
            end else if (app_xfr_done) begin
                m_owner = -1;
            end
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("cyc_port_ack", port_ack, exp_port_ack);
            checkOutput("cyc_owner_vld", owner_vld, m_owner >= 0);
            checkOutput("cyc_app_req", app_req, (m_owner >= 0) && !m_acked);
            checkOutput("cyc_tmo_err", ack_tmo_err, exp_tmo);
            if (m_owner >= 0) begin
                checkOutput("cyc_owner_id", owner_id, m_owner);
                checkOutput("cyc_addr", app_req_addr, exp_addr);
                checkOutput("cyc_len", app_req_len, exp_len);
                checkOutput("cyc_wr_n", app_req_wr_n, exp_wr_n);
            end
        end
    end

    task automatic waitGrant(input int exp_id);
        int n;
        n = 0;
        while (app_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("grant_seen", app_req, 1);
        checkOutput("grant_id", owner_id, exp_id);
        checkOutput("grant_vld", owner_vld, 1);
    endtask

    task automatic finishXfr(input int exp_id, input int ack_dly, input int done_dly, input bit drop);
        logic [N-1:0] one_hot;
        one_hot = 4'b0001 << exp_id;
        repeat (ack_dly) tick();
        app_req_ack = 1'b1;
        if (done_dly == 0) app_xfr_done = 1'b1;
        tick();
        app_req_ack  = 1'b0;
        app_xfr_done = 1'b0;
        checkOutput("ack_pulse", port_ack, one_hot);
        checkOutput("ack_req_low", app_req, 0);
        if (drop) port_req[exp_id] = 1'b0;
        if (done_dly > 0) begin
            repeat (done_dly - 1) tick();
            app_xfr_done = 1'b1;
            tick();
            app_xfr_done = 1'b0;
        end
        checkOutput("done_vld_low", owner_vld, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int pulses;
        int pulse_cycle;

        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_owner_vld", owner_vld, 0);
        checkOutput("rst_app_req", app_req, 0);
        checkOutput("rst_port_ack", port_ack, 0);
        checkOutput("rst_addr", app_req_addr, 0);
        tick();
        tick();
        reset_n = 1'b1;

        $display("[TB] all four ports requesting continuously");
        for (int p = 0; p < N; p++)
            applyStimulus(p, 26'h0100000 + 26'(p * 'h111), 9'(4 + p), p[0], 1'b1);
        for (int i = 0; i < 6; i++) begin
            waitGrant(order[i]);
            finishXfr(order[i], 1, 2, 1'b0);
        end
        port_req = '0;

        $display("[TB] single request from port 2");
        applyStimulus(2, 26'h0012345, 9'd8, 1'b0, 1'b1);
        waitGrant(2);
        checkOutput("t1_addr", app_req_addr, 26'h0012345);
        checkOutput("t1_len", app_req_len, 8);
        checkOutput("t1_wr_n", app_req_wr_n, 0);
        finishXfr(2, 2, 3, 1'b1);

        $display("[TB] ack and done in the same cycle");
        applyStimulus(1, 26'h0000AB0, 9'd2, 1'b1, 1'b1);
        applyStimulus(3, 26'h2000000, 9'd16, 1'b0, 1'b1);
        waitGrant(3);
        finishXfr(3, 0, 0, 1'b1);
        checkOutput("t3_idle_req", app_req, 0);
        tick();
        checkOutput("t3_regrant_req", app_req, 1);
        checkOutput("t3_regrant_id", owner_id, 1);
        checkOutput("t3_regrant_addr", app_req_addr, 26'h0000AB0);
        finishXfr(1, 1, 2, 1'b1);

        $display("[TB] ack withheld past the timeout");
        applyStimulus(3, 26'h0055AA0, 9'd1, 1'b1, 1'b1);
        waitGrant(3);
        pulses = 0;
        pulse_cycle = 0;
        if (ack_tmo_err) begin
            pulses++;
            pulse_cycle = 1;
        end
        for (int c = 2; c <= 300; c++) begin
            tick();
            if (ack_tmo_err === 1'b1) begin
                pulses++;
                pulse_cycle = c;
            end
        end
        checkOutput("t4_pulse_count", pulses, 1);
        checkOutput("t4_pulse_cycle", pulse_cycle, 255);
        checkOutput("t4_req_held", app_req, 1);
        finishXfr(3, 0, 3, 1'b1);

        $display("[TB] reset during a transfer");
        applyStimulus(3, 26'h0777777, 9'd5, 1'b0, 1'b1);
        waitGrant(3);
        app_req_ack = 1'b1;
        tick();
        app_req_ack = 1'b0;
        port_req[3] = 1'b1;
        applyStimulus(0, 26'h3FFFFFF, 9'd0, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_vld", owner_vld, 0);
        checkOutput("t5_rst_req", app_req, 0);
        checkOutput("t5_rst_id", owner_id, 0);
        checkOutput("t5_rst_addr", app_req_addr, 0);
        checkOutput("t5_rst_len", app_req_len, 0);
        checkOutput("t5_rst_ack", port_ack, 0);
        #2 reset_n = 1'b1;
        tick();
        checkOutput("t5_first_id", owner_id, 0);
        checkOutput("t5_zero_len", app_req_len, 0);
        checkOutput("t5_max_addr", app_req_addr, 26'h3FFFFFF);
        finishXfr(0, 1, 1, 1'b1);
        waitGrant(3);
        finishXfr(3, 1, 1, 1'b1);

        $display("[TB] port 1 drops its request before the ack");
        app_xfr_done = 1'b1;
        tick();
        app_xfr_done = 1'b0;
        checkOutput("t6_idle_done", owner_vld, 0);
        applyStimulus(1, 26'h0001000, 9'd32, 1'b0, 1'b1);
        waitGrant(1);
        port_req[1] = 1'b0;
        repeat (3) tick();
        checkOutput("t6_req_kept", app_req, 1);
        finishXfr(1, 0, 2, 1'b1);

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
